mul_div_unit: RTL and testbench
===============================

// Module: mul_div_unit
// PURPOSE
//  Iterative RV32M multiply/divide unit in the execute stage, alongside the ALU.
//  - Consumes the same rs1/rs2 operands as the ALU (A_i/B_i).
//  - Its result goes to the write-back mux in place of ALU_Result_o.
//  - Control stalls PC/fetch while Busy_o=1.
// PARAMETERS
//  XLEN      32   operand/result width; iteration count = XLEN
// PORTS
//  clk              in   1     single clock, rising edge
//  reset            in   1     asynchronous, active-low reset
//  Start_i          in   1     request; sampled only in IDLE or DONE
//  MDU_Operation_i  in   3     funct3: 0 MUL,1 MULH,2 MULHSU,3 MULHU,4 DIV,5 DIVU,6 REM,7 REMU
//  A_i              in   XLEN  rs1 operand
//  B_i              in   XLEN  rs2 operand
//  Busy_o           out  1     high in CALC; requester must hold
//  Done_o           out  1     one-cycle pulse: result valid
//  MDU_Result_o     out  XLEN  result; held from Done_o until the next accepted Start_i
//  Zero_o           out  1     (MDU_Result_o == 0), registered with the result
// BEHAVIOUR
//  - Reset (reset=0, async): state=IDLE; Busy_o=0, Done_o=0, MDU_Result_o=0, Zero_o=1.
//    Any operation in flight is aborted and discarded.
//  - FSM states: IDLE, CALC, DONE.
//    - IDLE -Start_i-> CALC, or DONE for the special cases below.
//    - CALC: counter runs XLEN-1..0; at count 0 -> DONE.
//    - DONE: Done_o=1 for exactly one cycle.
//      Start_i=1 -> new op accepted back-to-back; else -> IDLE.
//  - Accept: op, A_i and B_i are registered on the accepting edge; later input changes are ignored.
//  - Start_i while Busy_o=1 is ignored; no queueing.
//  - Latency: Start_i sampled at edge N -> Done_o high in the cycle after edge N+XLEN+1 (33 for XLEN=32).
//  - Sign handling:
//    - Signed operands are converted to magnitude; the result sign is fixed up in DONE entry.
//    - MULH: both operands signed. MULHSU: A signed, B unsigned. MULHU: both unsigned.
//  - MUL* datapath: radix-2 shift-add, 2*XLEN product register, one bit per cycle.
//    MUL returns product[XLEN-1:0]; MULH* return product[2*XLEN-1:XLEN].
//  - DIV* datapath: restoring division, one quotient bit per cycle.
//    - Remainder takes the sign of the dividend.
//    - Quotient is negative iff operand signs differ and the divisor is nonzero.
//  - Special cases skip CALC (IDLE->DONE, Done_o 2 cycles after accept):
//    - Divide by zero: DIV/DIVU -> all ones; REM/REMU -> A_i.
//    - DIV overflow (A=0x80000000, B=-1): DIV -> 0x80000000; REM -> 0.
//  - Zero_o updates only when the result register loads.
// CONFIGURATION
//  - MDU_DIV_EN defined:
//    - Full RV32M; divider datapath and special-case logic are compiled in.
//  - MDU_DIV_EN undefined:
//    - No divider hardware.
//    - funct3 4..7 take the 2-cycle path with result 0, Zero_o=1.
//    - Multiply behaviour is unchanged.
// STRUCTURE
//  - Shared package mdu_pkg:
//    - funct3 localparams MUL..REMU.
//    - FSM state encoding (IDLE=2'b00, CALC=2'b01, DONE=2'b10).
//    - XLEN default.
//  - Sub-module mdu_iter_core: one shift-add / restore-subtract step, combinational.
//    The top level keeps the FSM, counter, operand/sign registers and result register.
// TESTING
//  1. Reset values.
//     Assert reset mid-CALC (cycle 10) -> Busy_o=0, Done_o=0, MDU_Result_o=0 immediately.
//     No Done_o after release.
//  2. MUL, A=7, B=-3 -> 0xFFFFFFEB, Done_o 33 cycles after Start_i.
//     MULHU, 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE.
//     MULHSU, A=-1, B=2 -> 0xFFFFFFFF.
//  3. DIV, -7/2 -> 0xFFFFFFFD. REM, -7/2 -> 0xFFFFFFFF.
//     DIVU, 100/7 -> 14. REMU, 100/7 -> 2.
//  4. Divide by zero: DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, both with Done_o 2 cycles after accept.
//     Overflow: DIV 0x80000000/-1 -> 0x80000000 and REM -> 0 (Zero_o=1).
//  5. Handshake:
//     - Start_i pulsed during CALC -> ignored.
//     - Start_i held in DONE -> second op accepted; Done_o pulses once per op.
//     - A_i changed after accept -> result unaffected.
//  6. With MDU_DIV_EN undefined: DIV 9/3 -> 0, Done_o at +2.
//     MUL 6*7 -> 42, timing as in test 2.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared constants for the RV32M multiply/divide unit: funct3 codes, FSM encoding, default width.
package mdu_pkg;

    localparam int MDU_XLEN = 32;

    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_CALC = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/mdu_iter_core.sv
// One iteration of the MDU datapath: radix-2 shift-add multiply or restoring-divide step.
// The divide step (and its select input) exists only when MDU_DIV_EN is defined.
module mdu_iter_core #(
    parameter int XLEN = 32
) (
`ifdef MDU_DIV_EN
    input  logic            i_div,
`endif
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0]   w_sum;
`ifdef MDU_DIV_EN
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;
`endif

    always_comb begin
        // Multiply: {hi,lo} is the product register, lo shifts out the multiplier LSB-first.
        w_sum = {1'b0, i_hi} + (i_lo[0] ? {1'b0, i_b} : '0);
        o_hi  = w_sum[XLEN:1];
        o_lo  = {w_sum[0], i_lo[XLEN-1:1]};
`ifdef MDU_DIV_EN
        // Divide: hi is the partial remainder, lo shifts the dividend out and the quotient in.
        w_shift = {i_hi, i_lo[XLEN-1]};
        w_ge    = (w_shift >= {1'b0, i_b});
        w_diff  = w_shift[XLEN-1:0] - i_b;
        if (i_div) begin
            o_hi = w_ge ? w_diff : w_shift[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], w_ge};
        end
`endif
    end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit (IDLE/CALC/DONE FSM, one bit per cycle).
// Define MDU_DIV_EN to build the divider; otherwise funct3 4..7 return 0 on the short path.
module mul_div_unit
    import mdu_pkg::*;
#(
    parameter int XLEN = MDU_XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            Start_i,
    input  logic [2:0]      MDU_Operation_i,
    input  logic [XLEN-1:0] A_i,
    input  logic [XLEN-1:0] B_i,
    output logic            Busy_o,
    output logic            Done_o,
    output logic [XLEN-1:0] MDU_Result_o,
    output logic            Zero_o
);

    localparam int CW = $clog2(XLEN);
`ifdef MDU_DIV_EN
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
`endif

    logic [1:0]      r_state;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_op;
    logic [XLEN-1:0] r_b, r_hi, r_lo, r_result;
    logic            r_neg, r_special, r_done, r_zero;

    logic            w_accept, w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_res_neg, w_special;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_spec_res, w_core_hi, w_core_lo, w_neg_hi, w_final;

    assign w_accept = Start_i & ((r_state == ST_IDLE) | ((r_state == ST_DONE) & (r_cnt == '0)));

    always_comb begin
        w_a_signed = (MDU_Operation_i == F_MULH) | (MDU_Operation_i == F_MULHSU) |
                     (MDU_Operation_i == F_DIV)  | (MDU_Operation_i == F_REM);
        w_b_signed = (MDU_Operation_i == F_MULH) | (MDU_Operation_i == F_DIV) |
                     (MDU_Operation_i == F_REM);
        w_a_neg    = w_a_signed & A_i[XLEN-1];
        w_b_neg    = w_b_signed & B_i[XLEN-1];
        w_a_mag    = w_a_neg ? -A_i : A_i;
        w_b_mag    = w_b_neg ? -B_i : B_i;
        // Remainder follows the dividend; everything else follows the operand sign product.
        w_res_neg  = (MDU_Operation_i[2] & MDU_Operation_i[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
        w_special  = 1'b0;
        w_spec_res = '0;
`ifdef MDU_DIV_EN
        if (MDU_Operation_i[2]) begin
            if (B_i == '0) begin
                w_special  = 1'b1;
                w_spec_res = MDU_Operation_i[1] ? A_i : '1;
            end else if (!MDU_Operation_i[0] && (A_i == MIN_NEG) && (B_i == '1)) begin
                w_special  = 1'b1;
                w_spec_res = MDU_Operation_i[1] ? '0 : A_i;
            end
        end
`else
        w_special  = MDU_Operation_i[2];
`endif
    end

    mdu_iter_core #(.XLEN(XLEN)) u_core (
`ifdef MDU_DIV_EN
        .i_div (r_op[2]),
`endif
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .i_b   (r_b),
        .o_hi  (w_core_hi),
        .o_lo  (w_core_lo)
    );

    // Upper half of the negated 2*XLEN product: carry into hi only when lo is all zeros.
    assign w_neg_hi = ~r_hi + XLEN'(r_lo == '0);

    always_comb begin
        w_final = '0;
        if (r_special)
            w_final = r_lo;
        else if (!r_op[2])
            w_final = (r_op == F_MUL) ? r_lo : (r_neg ? w_neg_hi : r_hi);
`ifdef MDU_DIV_EN
        else if (r_op[1])
            w_final = r_neg ? -r_hi : r_hi;
        else
            w_final = r_neg ? -r_lo : r_lo;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_op      <= '0;
            r_b       <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_neg     <= 1'b0;
            r_special <= 1'b0;
            r_done    <= 1'b0;
            r_result  <= '0;
            r_zero    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_CALC: begin
                    r_hi <= w_core_hi;
                    r_lo <= w_core_lo;
                    if (r_cnt == '0) r_state <= ST_DONE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                ST_DONE: begin
                    // Special cases arrive with r_cnt=1 and wait one cycle before publishing.
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - 1'b1;
                    end else begin
                        r_result <= w_final;
                        r_zero   <= (w_final == '0);
                        r_done   <= 1'b1;
                        r_state  <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
            if (w_accept) begin
                r_op      <= MDU_Operation_i;
                r_b       <= w_b_mag;
                r_hi      <= '0;
                r_lo      <= w_special ? w_spec_res : w_a_mag;
                r_neg     <= w_res_neg;
                r_special <= w_special;
                r_cnt     <= w_special ? CW'(1) : CW'(XLEN-1);
                r_state   <= w_special ? ST_DONE : ST_CALC;
            end
        end
    end

    assign Busy_o       = (r_state == ST_CALC);
    assign Done_o       = r_done;
    assign MDU_Result_o = r_result;
    assign Zero_o       = r_zero;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit; divide vectors run only when MDU_DIV_EN is defined.
module tb_mul_div_unit;

    localparam logic [2:0] OP_MUL = 3'd0, OP_MULH = 3'd1, OP_MULHSU = 3'd2, OP_MULHU = 3'd3;
    localparam logic [2:0] OP_DIV = 3'd4, OP_DIVU = 3'd5, OP_REM = 3'd6, OP_REMU = 3'd7;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        Start_i = 1'b0;
    logic [2:0]  MDU_Operation_i = '0;
    logic [31:0] A_i = '0, B_i = '0;
    logic        Busy_o, Done_o, Zero_o;
    logic [31:0] MDU_Result_o;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    mul_div_unit dut (
        .clk             (clk),
        .reset           (reset),
        .Start_i         (Start_i),
        .MDU_Operation_i (MDU_Operation_i),
        .A_i             (A_i),
        .B_i             (B_i),
        .Busy_o          (Busy_o),
        .Done_o          (Done_o),
        .MDU_Result_o    (MDU_Result_o),
        .Zero_o          (Zero_o)
    );

    always @(posedge clk) if (Done_o) done_cnt <= done_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag, output int lat);
        bit seen = 1'b0;
        lat = 0;
        while (!seen && lat < 100) begin
            @(posedge clk); #1;
            lat++;
            if (Done_o) seen = 1'b1;
        end
        chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // Issue one op, scramble the inputs right after the accepting edge, check latency and result.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_res, input int exp_lat);
        int lat;
        @(negedge clk);
        Start_i = 1'b1; MDU_Operation_i = op; A_i = a; B_i = b;
        @(posedge clk); #1;
        Start_i = 1'b0;
        A_i = $urandom; B_i = $urandom; MDU_Operation_i = 3'($urandom_range(0, 7));
        wait_done(tag, lat);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_res"}, MDU_Result_o, exp_res);
        chk({tag, "_zero"}, 32'(Zero_o), 32'(exp_res == 32'd0));
        @(posedge clk); #1;
        chk({tag, "_pulse"}, 32'(Done_o), 32'd0);
        chk({tag, "_hold"}, MDU_Result_o, exp_res);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int lat, d0;
        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(Busy_o), 32'd0);
        chk("rst_done", 32'(Done_o), 32'd0);
        chk("rst_res", MDU_Result_o, 32'd0);
        chk("rst_zero", 32'(Zero_o), 32'd1);
        @(negedge clk); reset = 1'b1;

        // Multiply
        run_op("mul_7_m3",  OP_MUL,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        run_op("mulhu_max", OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_op("mulhsu_m1", OP_MULHSU, 32'hFFFF_FFFF, 32'd2,        32'hFFFF_FFFF, 33);
        run_op("mulh_min",  OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);

`ifdef MDU_DIV_EN
        run_op("div_m7_2",  OP_DIV,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
        run_op("rem_m7_2",  OP_REM,  32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
        run_op("divu_100",  OP_DIVU, 32'd100,       32'd7, 32'd14,        33);
        run_op("remu_100",  OP_REMU, 32'd100,       32'd7, 32'd2,         33);
        run_op("divu_by0",  OP_DIVU, 32'd5,         32'd0, 32'hFFFF_FFFF, 2);
        run_op("rem_by0",   OP_REM,  32'd5,         32'd0, 32'd5,         2);
        run_op("div_ovf",   OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
        run_op("rem_ovf",   OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        2);
`else
        run_op("nodiv_div", OP_DIV, 32'd9, 32'd3, 32'd0,  2);
        run_op("nodiv_mul", OP_MUL, 32'd6, 32'd7, 32'd42, 33);
`endif

        // Start pulsed during CALC is ignored
        d0 = done_cnt;
        @(negedge clk);
        Start_i = 1'b1; MDU_Operation_i = OP_MULHU; A_i = 32'hFFFF_FFFF; B_i = 32'hFFFF_FFFF;
        @(negedge clk);
        Start_i = 1'b0;
        repeat (5) @(negedge clk);
        chk("calc_busy", 32'(Busy_o), 32'd1);
        Start_i = 1'b1; MDU_Operation_i = OP_MUL; A_i = 32'd1; B_i = 32'd1;
        @(negedge clk);
        Start_i = 1'b0;
        wait_done("ign", lat);
        chk("ign_res", MDU_Result_o, 32'hFFFF_FFFE);
        repeat (40) @(posedge clk);
        #1;
        chk("ign_one_done", 32'(done_cnt - d0), 32'd1);

        // Start held through DONE: back-to-back ops, inputs changed after first accept
        d0 = done_cnt;
        @(negedge clk);
        Start_i = 1'b1; MDU_Operation_i = OP_MUL; A_i = 32'd3; B_i = 32'd4;
        @(posedge clk); #1;
        A_i = 32'd5; B_i = 32'd5;
        wait_done("b2b1", lat);
        chk("b2b1_res", MDU_Result_o, 32'd12);
        @(posedge clk); #1;
        Start_i = 1'b0;
        wait_done("b2b2", lat);
        chk("b2b2_res", MDU_Result_o, 32'd25);
        repeat (3) @(posedge clk);
        #1;
        chk("b2b_two_done", 32'(done_cnt - d0), 32'd2);

        // Reset asserted mid-CALC aborts the op
        @(negedge clk);
        Start_i = 1'b1; MDU_Operation_i = OP_MUL; A_i = 32'd7; B_i = 32'd9;
        @(posedge clk); #1;
        Start_i = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        chk("abort_busy_pre", 32'(Busy_o), 32'd1);
        d0 = done_cnt;
        reset = 1'b0;
        #1;
        chk("abort_busy", 32'(Busy_o), 32'd0);
        chk("abort_done", 32'(Done_o), 32'd0);
        chk("abort_res", MDU_Result_o, 32'd0);
        chk("abort_zero", 32'(Zero_o), 32'd1);
        @(negedge clk); reset = 1'b1;
        repeat (45) @(posedge clk);
        #1;
        chk("abort_no_done", 32'(done_cnt - d0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
